// File: rtl/router_output_allocator_pkg.sv
// Shared router definitions: allocator FSM states and router port indices.
package router_output_allocator_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int SOUTH = 2;
    localparam int EAST  = 3;
    localparam int WEST  = 4;

endpackage

// File: rtl/router_output_allocator_rr_priority_select.sv
// Rotating-priority one-hot selector: first set request at or above ptr, wrapping to 0.
module rr_priority_select #(
    parameter int N         = 5,
    parameter int PTR_WIDTH = $clog2(N)
) (
    input  logic [N-1:0]         req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [N-1:0]         grant
);

    logic found_s;

    // Walk the requests starting at ptr and keep only the first hit.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (!found_s && req[idx]) begin
                grant[idx] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/router_output_allocator.sv
// Output-port allocator: wormhole packet locking, round-robin arbitration and credit tracking.
module router_output_allocator
    import router_output_allocator_pkg::*;
#(
    parameter  int NUM_INPUTS   = 5,
    parameter  int CREDIT_DEPTH = 1,
    localparam int CREDIT_WIDTH = $clog2(CREDIT_DEPTH + 1),
    localparam int IDX_WIDTH    = $clog2(NUM_INPUTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_INPUTS-1:0]   req,
    input  logic [NUM_INPUTS-1:0]   req_is_tail,
    input  logic [NUM_INPUTS-1:0]   turn_disable,
    input  logic                    credit_in,
    output logic [NUM_INPUTS-1:0]   grant,
    output logic                    send_out,
    output logic                    locked,
    output logic [IDX_WIDTH-1:0]    owner_idx,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    credit_err
);

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(CREDIT_DEPTH);

    alloc_state_t            state_r;
    alloc_state_t            state_nxt_s;
    logic [IDX_WIDTH-1:0]    rr_ptr_r;
    logic [IDX_WIDTH-1:0]    rr_ptr_nxt_s;
    logic [IDX_WIDTH-1:0]    owner_r;
    logic [IDX_WIDTH-1:0]    owner_nxt_s;
    logic [CREDIT_WIDTH-1:0] credit_r;
    logic [CREDIT_WIDTH-1:0] credit_nxt_s;
    logic                    err_r;
    logic                    err_set_s;

    logic [NUM_INPUTS-1:0]   eligible_s;
    logic [NUM_INPUTS-1:0]   idle_pick_s;
    logic [NUM_INPUTS-1:0]   grant_s;
    logic [IDX_WIDTH-1:0]    win_s;
    logic                    win_tail_s;
    logic                    send_s;

    function automatic logic [IDX_WIDTH-1:0] ptr_inc(input logic [IDX_WIDTH-1:0] p);
        if (int'(p) == NUM_INPUTS - 1) begin
            return '0;
        end else begin
            return p + IDX_WIDTH'(1);
        end
    endfunction

    assign eligible_s = req & ~turn_disable;

    rr_priority_select #(
        .N         (NUM_INPUTS),
        .PTR_WIDTH (IDX_WIDTH)
    ) u_rr (
        .req   (eligible_s),
        .ptr   (rr_ptr_r),
        .grant (idle_pick_s)
    );

    // Zero-latency grant; a locked owner bypasses arbitration and turn restrictions.
    always_comb begin
        grant_s = '0;
        if (rst) begin
            grant_s = '0;
        end else if (credit_r == '0) begin
            grant_s = '0;
        end else if (state_r == IDLE) begin
            grant_s = idle_pick_s;
        end else if (req[owner_r]) begin
            grant_s[owner_r] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Encode the one-hot winner back to an index.
    always_comb begin
        win_s = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_s[i]) begin
                win_s = IDX_WIDTH'(i);
            end else begin
                win_s = win_s;
            end
        end
    end

    assign win_tail_s = req_is_tail[win_s];
    assign send_s     = |grant_s;

    // Packet-level FSM; the round-robin pointer moves only when a packet completes.
    always_comb begin
        state_nxt_s  = state_r;
        rr_ptr_nxt_s = rr_ptr_r;
        owner_nxt_s  = owner_r;
        case (state_r)
            IDLE: begin
                if (send_s && win_tail_s) begin
                    rr_ptr_nxt_s = ptr_inc(win_s);
                end else if (send_s) begin
                    state_nxt_s = LOCKED;
                    owner_nxt_s = win_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCKED: begin
                if (send_s && win_tail_s) begin
                    state_nxt_s  = IDLE;
                    rr_ptr_nxt_s = ptr_inc(owner_r);
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Credit bookkeeping; a return on a full counter saturates and flags an error.
    always_comb begin
        credit_nxt_s = credit_r;
        err_set_s    = 1'b0;
        if (credit_in && !send_s) begin
            if (credit_r == CREDIT_FULL) begin
                err_set_s = 1'b1;
            end else begin
                credit_nxt_s = credit_r + CREDIT_WIDTH'(1);
            end
        end else if (send_s && !credit_in) begin
            credit_nxt_s = credit_r - CREDIT_WIDTH'(1);
        end else begin
            credit_nxt_s = credit_r;
        end
    end

    // State registers with synchronous reset; reset drops any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            owner_r  <= '0;
            credit_r <= CREDIT_FULL;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            owner_r  <= owner_nxt_s;
            credit_r <= credit_nxt_s;
            err_r    <= err_r | err_set_s;
        end
    end

    assign grant        = grant_s;
    assign send_out     = send_s;
    assign locked       = (state_r == LOCKED);
    assign owner_idx    = owner_r;
    assign credit_count = credit_r;
    assign credit_err   = err_r;

endmodule

// File: tb/tb_router_output_allocator.sv
// Bench for router_output_allocator: packet-level model plus directed literal scenarios.
module tb_router_output_allocator;

    localparam int N = 5;
    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic [N-1:0] req = '0, req_is_tail = '0, turn_disable = '0;
    logic         credit_in = 1'b0;
    logic [N-1:0] grant;
    logic         send_out, locked, credit_err;
    logic [2:0]   owner_idx;
    logic [2:0]   credit_count;

    logic         rst_b = 1'b1;
    logic [N-1:0] req_b = '0, tail_b = '0, td_b = '0;
    logic         credit_in_b = 1'b0;
    logic [N-1:0] grant_b;
    logic         send_b, locked_b, err_b;
    logic [2:0]   owner_b;
    logic [0:0]   count_b;

    router_output_allocator #(.NUM_INPUTS(N), .CREDIT_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .req(req), .req_is_tail(req_is_tail),
        .turn_disable(turn_disable), .credit_in(credit_in), .grant(grant),
        .send_out(send_out), .locked(locked), .owner_idx(owner_idx),
        .credit_count(credit_count), .credit_err(credit_err)
    );

    router_output_allocator #(.NUM_INPUTS(N), .CREDIT_DEPTH(1)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .req_is_tail(tail_b),
        .turn_disable(td_b), .credit_in(credit_in_b), .grant(grant_b),
        .send_out(send_b), .locked(locked_b), .owner_idx(owner_b),
        .credit_count(count_b), .credit_err(err_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet-level model of dut: lock flag, owner, next-priority input, credits.
    bit lk_m = 1'b0, err_m = 1'b0, prev_send = 1'b0, started = 1'b0;
    int own_m = 0, ptr_m = 0, cnt_m = D, outstanding = 0, credit_mode = 0;

    function automatic int pick();
        if (rst || cnt_m == 0) return -1;
        if (lk_m) return req[own_m] ? own_m : -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr_m + k) % N;
            if (req[j] && !turn_disable[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int w;
        bit s;
        w = pick();
        s = (w >= 0);
        if (rst) begin
            lk_m <= 1'b0; own_m <= 0; ptr_m <= 0; cnt_m <= D;
            err_m <= 1'b0; outstanding <= 0; prev_send <= 1'b0;
        end else begin
            if (s && !lk_m) begin
                if (req_is_tail[w]) ptr_m <= (w + 1) % N;
                else begin lk_m <= 1'b1; own_m <= w; end
            end else if (s && lk_m && req_is_tail[w]) begin
                lk_m  <= 1'b0;
                ptr_m <= (own_m + 1) % N;
            end
            if (credit_in && !s && cnt_m == D) err_m <= 1'b1;
            else cnt_m <= cnt_m - int'(s) + int'(credit_in);
            if (outstanding + int'(s) - int'(credit_in) < 0) outstanding <= 0;
            else outstanding <= outstanding + int'(s) - int'(credit_in);
            prev_send <= s;
        end
    end

    always @(negedge clk) begin : compare
        int w;
        if (started) begin
            w = pick();
            chk("model_grant", grant, (w >= 0) ? (32'd1 << w) : 32'd0);
            chk("model_send", send_out, (w >= 0) ? 32'd1 : 32'd0);
            chk("model_locked", locked, lk_m);
            chk("model_owner", owner_idx, own_m);
            chk("model_credit", credit_count, cnt_m);
            chk("model_err", credit_err, err_m);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (credit_mode)
            1: credit_in = prev_send;
            2: credit_in = (outstanding > 0) && ($urandom_range(0, 2) == 0);
            default: ;
        endcase
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1; req = '1; req_is_tail = '0; turn_disable = '0; credit_in = 1'b0;
        @(negedge clk);
        chk("rst_grant", grant, 32'd0);
        chk("rst_send", send_out, 32'd0);
        step();
        rst = 1'b0; req = '0; credit_in = 1'b0;
        @(negedge clk);
        chk("post_rst_credit", credit_count, D);
        chk("post_rst_locked", locked, 32'd0);
        chk("post_rst_owner", owner_idx, 32'd0);
        chk("post_rst_err", credit_err, 32'd0);
    endtask

    logic [N-1:0] t38_req [5] = '{5'b01100, 5'b01100, 5'b01100, 5'b01100, 5'b01000};
    logic [N-1:0] t38_tl  [5] = '{5'b01000, 5'b01000, 5'b01000, 5'b01100, 5'b01000};
    logic [N-1:0] t38_g   [5] = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01000};
    bit           t38_lk  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [N-1:0] t40_td  [5] = '{5'b00010, 5'b00000, 5'b00010, 5'b00010, 5'b00010};
    logic [N-1:0] t40_tl  [5] = '{5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00010};
    logic [N-1:0] t40_g   [5] = '{5'b00000, 5'b00010, 5'b00010, 5'b00010, 5'b00000};
    bit           t40_lk  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        @(posedge clk);
        #1;
        started = 1'b1;

        // All-tail requests rotate one grant per cycle.
        credit_mode = 1;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step();
            req = 5'b11111; req_is_tail = 5'b11111; turn_disable = '0;
            @(negedge clk);
            chk("rr_rotate", grant, 32'd1 << (k % N));
        end

        // Multi-flit packet on input 2 holds off input 3.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step();
            req = t38_req[k]; req_is_tail = t38_tl[k]; turn_disable = '0;
            @(negedge clk);
            chk("pkt_grant", grant, t38_g[k]);
            chk("pkt_locked", locked, t38_lk[k]);
        end

        // Turn restriction blocks a new packet but not an established owner.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step();
            req = 5'b00010; req_is_tail = t40_tl[k]; turn_disable = t40_td[k];
            @(negedge clk);
            chk("turn_grant", grant, t40_g[k]);
            chk("turn_locked", locked, t40_lk[k]);
        end

        // Credit return on a full counter saturates and latches the error.
        credit_mode = 0;
        do_reset();
        step();
        req = '0; credit_in = 1'b1;
        @(negedge clk);
        chk("ovf_err_same_cycle", credit_err, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            credit_in = 1'b0;
            @(negedge clk);
            chk("ovf_count", credit_count, D);
            chk("ovf_err_sticky", credit_err, 32'd1);
        end

        // Exhaust credits mid-packet, then reset.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step();
            req = 5'b00001; req_is_tail = '0; credit_in = 1'b0;
            @(negedge clk);
            chk("drain_grant", grant, (k < 4) ? 32'd1 : 32'd0);
            chk("drain_count", credit_count, D - k);
        end
        chk("drain_locked", locked, 32'd1);
        step();
        rst = 1'b1; req = 5'b11111;
        @(negedge clk);
        chk("rst_locked_grant", grant, 32'd0);
        step();
        rst = 1'b0; req = 5'b11110; turn_disable = 5'b00100;
        @(negedge clk);
        chk("after_rst_grant", grant, 32'b00010);
        chk("after_rst_count", credit_count, D);
        chk("after_rst_locked", locked, 32'd0);

        // Randomized traffic with credits returned after random delays.
        credit_mode = 2;
        for (int k = 0; k < 3000; k++) begin
            step();
            rst          = ($urandom_range(0, 299) == 0);
            req          = N'($urandom);
            req_is_tail  = N'($urandom);
            turn_disable = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            @(negedge clk);
        end

        // Single-credit downstream with 3-cycle credit return.
        credit_mode = 0;
        step();
        rst = 1'b0; req = '0; credit_in = 1'b0;
        rst_b = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            step();
            rst_b = 1'b0; req_b = 5'b00010; tail_b = '0; td_b = '0;
            credit_in_b = (k % 4 == 3);
            @(negedge clk);
            chk("d1_grant", grant_b, (k % 4 == 0) ? 32'b00010 : 32'd0);
            chk("d1_count", count_b, (k % 4 == 0) ? 32'd1 : 32'd0);
            chk("d1_send", send_b, (k % 4 == 0) ? 32'd1 : 32'd0);
        end
        chk("d1_locked", locked_b, 32'd1);
        chk("d1_owner", owner_b, 32'd1);
        chk("d1_err", err_b, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
